dmem_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the core's load/store port.

---
 rtl/dmem_responder.sv | 207 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: memory-side end of the core's load/store port.
// One request at a time over valid/ready, a programmable wait, then a response
// held until accepted. Stores commit on the accept edge with lane placement;
// loads return sign- or zero-extended data; bad accesses return rsp_err_o.
//
// Ports:
//   clk_i, rst_ni            clock (rising edge), asynchronous active-low reset
//   req_valid_i / req_ready_o request handshake (ready only while idle)
//   req_we_i                 1 = store, 0 = load
//   req_addr_i               byte address
//   req_wdata_i              store data, right-aligned
//   req_size_i               00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned_i           load zero-extends when 1, sign-extends when 0
//   rsp_valid_o / rsp_ready_i response handshake
//   rsp_rdata_o              load result, 0 for stores and errors
//   rsp_err_o                misaligned, out-of-range or illegal size
module dmem_responder #(
    parameter int unsigned DEPTH       = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [31:0] SizeBytes = 32'(DEPTH * 4);
    localparam logic [3:0]  WaitInit  = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e      state_q;
    logic [3:0]  cnt_q;
    logic        we_q;
    logic [31:0] addr_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_rdata_q;
    logic        rsp_err_q;

    logic [31:0] mem_q [DEPTH];

    logic        is_idle;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [1:0]  sel_size;
    logic        sel_uns;
    logic [31:0] off;
    logic        bad_size;
    logic        misalign;
    logic        out_of_range;
    logic        acc_err;
    logic [AW-1:0] word_idx;
    logic [1:0]  lane;
    logic [31:0] rd_word;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_data;
    logic [31:0] rsp_data_next;
    logic        wr_en;
    logic [3:0]  wr_be;
    logic [31:0] wr_data;

    assign is_idle = (state_q == StIdle);

    // While idle the live request is decoded (accept edge); afterwards the
    // latched copy is used so the read happens on the WAIT->RESP edge.
    assign sel_we   = is_idle ? req_we_i       : we_q;
    assign sel_addr = is_idle ? req_addr_i     : addr_q;
    assign sel_size = is_idle ? req_size_i     : size_q;
    assign sel_uns  = is_idle ? req_unsigned_i : uns_q;

    // Wrapping subtraction also makes addresses below BASE_ADDR out of range.
    assign off          = sel_addr - BASE_ADDR;
    assign out_of_range = (off >= SizeBytes);

    always_comb begin
        bad_size = 1'b0;
        misalign = 1'b0;
        case (sel_size)
            2'b01:   misalign = sel_addr[0];
            2'b10:   misalign = |sel_addr[1:0];
            2'b11:   bad_size = 1'b1;
            default: ;
        endcase
    end

    assign acc_err  = bad_size | misalign | out_of_range;
    assign word_idx = off[AW+1:2];
    assign lane     = off[1:0];
    assign rd_word  = mem_q[word_idx];
    assign byte_sel = rd_word[{lane, 3'b000} +: 8];
    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_data = rd_word;
        case (sel_size)
            2'b00:   load_data = {{24{~sel_uns & byte_sel[7]}}, byte_sel};
            2'b01:   load_data = {{16{~sel_uns & half_sel[15]}}, half_sel};
            default: load_data = rd_word;
        endcase
    end

    assign rsp_data_next = (acc_err | sel_we) ? 32'h0 : load_data;

    // Store lane placement: replicate data across lanes, enable only the target bytes.
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = req_wdata_i;
        case (req_size_i)
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{req_wdata_i[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{req_wdata_i[15:0]}};
            end
            2'b10:   wr_be = 4'b1111;
            default: ;
        endcase
    end

    assign wr_en = is_idle && req_valid_i && req_we_i && !acc_err;

    // Array has no reset; a committed store survives a later reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) begin
                    mem_q[word_idx][8*b +: 8] <= wr_data[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_valid_i) begin
                        we_q   <= req_we_i;
                        addr_q <= req_addr_i;
                        size_q <= req_size_i;
                        uns_q  <= req_unsigned_i;
                        if (WAIT_CYCLES == 0) begin
                            rsp_rdata_q <= rsp_data_next;
                            rsp_err_q   <= acc_err;
                            state_q     <= StResp;
                        end else begin
                            cnt_q   <= WaitInit;
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd1) begin
                        rsp_rdata_q <= rsp_data_next;
                        rsp_err_q   <= acc_err;
                        state_q     <= StResp;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    // rsp_valid rises one edge after entering RESP, giving
                    // WAIT_CYCLES+1 clocks from accept to response.
                    if (!rsp_valid_q) begin
                        rsp_valid_q <= 1'b1;
                    end else if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign req_ready_o = is_idle;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int unsigned TbDepth = 1024;
    localparam int unsigned Lat     = 3;
    localparam int unsigned ZDepth  = 16;
    localparam logic [31:0] ZBase   = 32'h0000_1000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT: WAIT_CYCLES = 2, BASE_ADDR = 0
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_size;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    // Second DUT: WAIT_CYCLES = 0, nonzero base, small array
    logic        z_rst_n;
    logic        z_req_valid, z_req_ready, z_req_we, z_req_unsigned;
    logic [31:0] z_req_addr, z_req_wdata;
    logic [1:0]  z_req_size;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [31:0] z_rsp_rdata;

    dmem_responder #(.DEPTH(TbDepth), .BASE_ADDR(32'h0), .WAIT_CYCLES(2)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .req_size_i(req_size),
        .req_unsigned_i(req_unsigned),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err)
    );

    dmem_responder #(.DEPTH(ZDepth), .BASE_ADDR(ZBase), .WAIT_CYCLES(0)) dut0 (
        .clk_i(clk), .rst_ni(z_rst_n),
        .req_valid_i(z_req_valid), .req_ready_o(z_req_ready), .req_we_i(z_req_we),
        .req_addr_i(z_req_addr), .req_wdata_i(z_req_wdata), .req_size_i(z_req_size),
        .req_unsigned_i(z_req_unsigned),
        .rsp_valid_o(z_rsp_valid), .rsp_ready_i(z_rsp_ready),
        .rsp_rdata_o(z_rsp_rdata), .rsp_err_o(z_rsp_err)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Byte-addressed reference image of the main DUT's array
    logic [7:0] mem_m [TbDepth*4];

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h want %08h", name, act, exp);
        end
    endtask

    // Reference: byte-granular memory, size = 2**req_size bytes, little-endian.
    function automatic void model(input logic we, input logic [31:0] addr,
                                  input logic [31:0] wdata, input logic [1:0] size,
                                  input logic uns, output logic [31:0] rd, output logic err);
        int unsigned n   = 1 << size;
        logic [31:0] off = addr - 32'h0;
        err = (size == 2'b11) || ((addr % n) != 0) || (off >= TbDepth * 4);
        rd  = 32'h0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < int'(n); i++) mem_m[off + i] = wdata[8*i +: 8];
            end else begin
                for (int i = 0; i < int'(n); i++) rd[8*i +: 8] = mem_m[off + i];
                if (!uns && n < 4 && rd[8*n-1]) rd = rd | ~((32'd1 << (8*n)) - 32'd1);
            end
        end
    endfunction

    function automatic logic dut_ready(input bit u);
        return u ? z_req_ready : req_ready;
    endfunction
    function automatic logic dut_valid(input bit u);
        return u ? z_rsp_valid : rsp_valid;
    endfunction
    function automatic logic [31:0] dut_rdata(input bit u);
        return u ? z_rsp_rdata : rsp_rdata;
    endfunction
    function automatic logic dut_err(input bit u);
        return u ? z_rsp_err : rsp_err;
    endfunction

    task automatic set_req(input bit u, input logic v, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] size, input logic uns);
        if (u) begin
            z_req_valid = v; z_req_we = we; z_req_addr = addr;
            z_req_wdata = wdata; z_req_size = size; z_req_unsigned = uns;
        end else begin
            req_valid = v; req_we = we; req_addr = addr;
            req_wdata = wdata; req_size = size; req_unsigned = uns;
        end
    endtask

    task automatic set_rsp_ready(input bit u, input logic v);
        if (u) z_rsp_ready = v;
        else rsp_ready = v;
    endtask

    // One full transaction; during a hold, a competing store is driven and must be ignored.
    task automatic xact(input string tag, input bit u, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_rd, input logic exp_err, input int hold);
        int          n = 0;
        int          lat = 0;
        bit          seen = 0;
        logic [31:0] rd;
        logic        er;
        int          exp_lat = u ? 1 : int'(Lat);
        @(negedge clk);
        while (!dut_ready(u) && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ready"}, {31'b0, dut_ready(u)}, 32'd1);
        if (!dut_ready(u)) return;
        set_req(u, 1'b1, we, addr, wdata, size, uns);
        @(posedge clk);
        #1 set_req(u, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        for (int k = 0; k <= 20 && !seen; k++) begin
            @(negedge clk);
            if (dut_valid(u)) begin
                seen = 1;
                lat  = k;
            end
        end
        check({tag, "_lat"}, seen ? 32'(lat) : 32'hFFFF_FFFF, 32'(exp_lat));
        if (!seen) return;
        rd = dut_rdata(u);
        er = dut_err(u);
        check({tag, "_rdata"}, rd, exp_rd);
        check({tag, "_err"}, {31'b0, er}, {31'b0, exp_err});
        for (int h = 0; h < hold; h++) begin
            set_req(u, 1'b1, 1'b1, {addr[31:2], 2'b00}, 32'hA5A5_A5A5, 2'b10, 1'b0);
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'b0, dut_valid(u)}, 32'd1);
            check({tag, "_hold_rdata"}, dut_rdata(u), rd);
            check({tag, "_hold_ready"}, {31'b0, dut_ready(u)}, 32'd0);
        end
        set_rsp_ready(u, 1'b1);
        @(posedge clk);
        #1;
        set_rsp_ready(u, 1'b0);
        set_req(u, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        check({tag, "_drop_valid"}, {31'b0, dut_valid(u)}, 32'd0);
        check({tag, "_idle_ready"}, {31'b0, dut_ready(u)}, 32'd1);
    endtask

    logic [31:0] mr;
    logic        me;

    initial begin
        rst_n = 1'b0;
        z_rst_n = 1'b0;
        rsp_ready = 1'b0;
        z_rsp_ready = 1'b0;
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        #12;
        check("rst_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rdata", rsp_rdata, 32'h0);
        check("rst_err", {31'b0, rsp_err}, 32'd0);
        check("rst_z_valid", {31'b0, z_rsp_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        z_rst_n = 1'b1;
        @(negedge clk);
        check("rst_ready", {31'b0, req_ready}, 32'd1);

        // Directed table: {we, addr, wdata, size, uns, exp_rdata, exp_err}
        vecs.push_back('{1'b1, 32'h10,   32'hDEAD_BEEF, 2'b10, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h10,   32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'h20,   32'h1122_3344, 2'b10, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h21,   32'hFFFF_FF80, 2'b00, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h21,   32'h0,         2'b00, 1'b0, 32'hFFFF_FF80, 1'b0});
        vecs.push_back('{1'b0, 32'h21,   32'h0,         2'b00, 1'b1, 32'h0000_0080, 1'b0});
        vecs.push_back('{1'b0, 32'h20,   32'h0,         2'b10, 1'b0, 32'h1122_8044, 1'b0});
        vecs.push_back('{1'b1, 32'h30,   32'hAABB_CCDD, 2'b10, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b1, 32'h32,   32'h5555_1234, 2'b01, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'h30,   32'h0,         2'b10, 1'b0, 32'h1234_CCDD, 1'b0});
        vecs.push_back('{1'b0, 32'h30,   32'h0,         2'b01, 1'b0, 32'hFFFF_CCDD, 1'b0});
        vecs.push_back('{1'b0, 32'h32,   32'h0,         2'b01, 1'b1, 32'h0000_1234, 1'b0});
        vecs.push_back('{1'b0, 32'h13,   32'h0,         2'b01, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h12,   32'h0,         2'b10, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h10,   32'h0,         2'b11, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h1000, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h13,   32'hFFFF_FFFF, 2'b01, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h12,   32'h0,         2'b10, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h10,   32'h0,         2'b11, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b1, 32'h1000, 32'h0,         2'b10, 1'b0, 32'h0,         1'b1});
        vecs.push_back('{1'b0, 32'h10,   32'h0,         2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0});
        vecs.push_back('{1'b1, 32'hFFC,  32'h0BAD_F00D, 2'b10, 1'b0, 32'h0,         1'b0});
        vecs.push_back('{1'b0, 32'hFFC,  32'h0,         2'b10, 1'b0, 32'h0BAD_F00D, 1'b0});
        vecs.push_back('{1'b0, 32'hFFE,  32'h0,         2'b01, 1'b1, 32'h0000_0BAD, 1'b0});

        foreach (vecs[i]) begin
            model(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size, vecs[i].uns, mr, me);
            xact($sformatf("vec%0d", i), 0, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                 vecs[i].size, vecs[i].uns, vecs[i].exp_rdata, vecs[i].exp_err, 0);
        end

        // Response back-pressure: five stalled cycles, competing store ignored
        xact("stall", 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 5);
        xact("stall_after", 0, 1'b0, 32'h10, 32'h0, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 0);

        // Reset during WAIT of a store: response dropped, store kept
        model(1'b1, 32'h40, 32'h5566_7788, 2'b10, 1'b0, mr, me);
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 32'h40, 32'h5566_7788, 2'b10, 1'b0);
        @(posedge clk);
        #1 set_req(0, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        check("midrst_valid", {31'b0, rsp_valid}, 32'd0);
        check("midrst_ready", {31'b0, req_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("midrst_quiet%0d", i), {31'b0, rsp_valid}, 32'd0);
        end
        xact("midrst_load", 0, 1'b0, 32'h40, 32'h0, 2'b10, 1'b0, 32'h5566_7788, 1'b0, 0);

        // Zero-wait instance: latency 1, base offset, below-base and past-end errors
        xact("z_st", 1, 1'b1, 32'h1004, 32'hCAFE_F00D, 2'b10, 1'b0, 32'h0, 1'b0, 0);
        xact("z_ld", 1, 1'b0, 32'h1004, 32'h0, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 1);
        xact("z_below", 1, 1'b0, 32'h0FFC, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        xact("z_past", 1, 1'b0, 32'h1040, 32'h0, 2'b10, 1'b0, 32'h0, 1'b1, 0);
        xact("z_stb", 1, 1'b1, 32'h103F, 32'h0000_007F, 2'b00, 1'b0, 32'h0, 1'b0, 0);
        xact("z_ldb", 1, 1'b0, 32'h103F, 32'h0, 2'b00, 1'b0, 32'h0000_007F, 1'b0, 0);
        @(negedge clk);
        z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h1008;
        z_req_wdata = 32'h1357_2468; z_req_size = 2'b10;
        @(posedge clk);
        #1 set_req(1, 1'b0, 1'b0, 32'h0, 32'h0, 2'b00, 1'b0);
        @(negedge clk);
        z_rst_n = 1'b0;
        #2;
        check("z_midrst_valid", {31'b0, z_rsp_valid}, 32'd0);
        @(negedge clk);
        z_rst_n = 1'b1;
        @(negedge clk);
        check("z_midrst_quiet", {31'b0, z_rsp_valid}, 32'd0);
        xact("z_midrst_load", 1, 1'b0, 32'h1008, 32'h0, 2'b10, 1'b0, 32'h1357_2468, 1'b0, 0);

        // Fill a window so random loads see defined data, then random traffic
        for (int a = 0; a < 256; a += 4) begin
            logic [31:0] wd = $urandom;
            model(1'b1, 32'(a), wd, 2'b10, 1'b0, mr, me);
            xact($sformatf("fill%0d", a), 0, 1'b1, 32'(a), wd, 2'b10, 1'b0, mr, me, 0);
        end
        for (int i = 0; i < 150; i++) begin
            logic        we   = 1'($urandom % 2);
            logic [1:0]  size = 2'($urandom % 4);
            logic        uns  = 1'($urandom % 2);
            logic [31:0] wd   = $urandom;
            logic [31:0] ad;
            case ($urandom % 8)
                0:       ad = 32'h1000 + ($urandom % 16);
                1:       ad = 32'hFFFF_FF00 | ($urandom % 256);
                default: ad = $urandom_range(0, 255);
            endcase
            model(we, ad, wd, size, uns, mr, me);
            xact($sformatf("rnd%0d", i), 0, we, ad, wd, size, uns, mr, me,
                 int'($urandom_range(0, 2)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
